mem_port_arbiter: RTL

- Shares the single RAM port between two requesters:
  - the instruction fetch path (read-only);
  - the load/store path (read and write).
- Grants at most one access per cycle and drives the RAM address/write signals.
- Tracks in-flight reads so each read response goes back to its issuer.
- Fetch is guaranteed forward progress under load/store pressure. A flush input discards stale in-flight fetch responses after a jump/redirect.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by fetch (read-only) and load/store; grant is combinational, read data returns READ_LATENCY cycles after grant.
// Backpressure: a requester holds req/addr/data until it sees gnt; load/store wins unless fetch has waited MAX_LS_STREAK ls grants.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int MAX_LS_STREAK = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                flush,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wmask,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  typedef struct packed {
    logic vld;
    logic own_if;
  } trk_t;

  trk_t [READ_LATENCY-1:0] trk;
  trk_t                    trk_last;
  logic [3:0]              streak;
  logic                    fetch_ok;
  logic                    force_if;
  logic                    rd_issue;
  logic                    any_vld;

  // Fetch is forced only once load/store has used up its streak while fetch was waiting.
  always_comb begin
    fetch_ok = if_req & ~flush;
    force_if = ls_req & fetch_ok & (streak == STREAK_MAX);
    if_gnt   = ~reset & fetch_ok & (force_if | ~ls_req);
    ls_gnt   = ~reset & ls_req & ~force_if;
    rd_issue = if_gnt | (ls_gnt & ~ls_we);
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (ls_gnt) begin
      ram_addr  = ls_addr;
      ram_we    = ls_we;
      ram_wdata = ls_wdata;
      ram_wmask = ls_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (ls_gnt && streak != STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  // Flush kills fetch-owned entries as they shift, so none survive past the flush cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk <= '0;
    end else begin
      trk[0].vld    <= rd_issue;
      trk[0].own_if <= if_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        trk[i].vld    <= trk[i-1].vld & ~(flush & trk[i-1].own_if);
        trk[i].own_if <= trk[i-1].own_if;
      end
    end
  end

  always_comb begin
    trk_last  = trk[READ_LATENCY-1];
    if_rvalid = ~reset & trk_last.vld & trk_last.own_if & ~flush;
    ls_rvalid = ~reset & trk_last.vld & ~trk_last.own_if;
    if_rdata  = ram_rdata;
    ls_rdata  = ram_rdata;
    any_vld   = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      any_vld = any_vld | trk[i].vld;
    end
    busy = ~reset & any_vld;
  end

endmodule
